// File: rtl/blram_pkg.sv
// Shared definitions for the dual-port block RAM: controller state encoding,
// write-mode selectors and a helper that sizes the read-latency delay line.
// No logic; imported by blram_lat_pipe and blram_dp.
package blram_pkg;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    localparam int WR_READ_FIRST  = 0;
    localparam int WR_WRITE_FIRST = 1;

    // The RAM output register provides the first cycle of read latency, so the
    // delay line behind it only needs the remaining cycles.
    function automatic int lat_stages(input int rd_lat);
        return (rd_lat > 1) ? rd_lat - 1 : 0;
    endfunction

endpackage

// File: rtl/blram_lat_pipe.sv
// Purpose: delay line for {valid, data, collision} behind the RAM output register.
// Latency: STAGES cycles (0 = straight wire); synchronous flush on rst.
// Backpressure: none; data in each stage only moves with its valid, so the
// output word holds its last value while valid is low.
// Ports: clk, rst; vld_in/dat_in/col_in from the RAM stage; vld_out/dat_out/col_out.
module blram_lat_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vld_in,
    input  logic [WIDTH-1:0] dat_in,
    input  logic             col_in,
    output logic             vld_out,
    output logic [WIDTH-1:0] dat_out,
    output logic             col_out
);

    if (STAGES == 0) begin : g_pass
        logic unused_pass;
        assign unused_pass = clk ^ rst;
        assign vld_out = vld_in;
        assign dat_out = dat_in;
        assign col_out = col_in;
    end else begin : g_pipe
        logic [STAGES-1:0] vld_q;
        logic [STAGES-1:0] col_q;
        logic [WIDTH-1:0]  dat_q [STAGES];

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q <= '0;
                col_q <= '0;
                for (int s = 0; s < STAGES; s++) dat_q[s] <= '0;
            end else begin
                vld_q[0] <= vld_in;
                col_q[0] <= vld_in & col_in;
                if (vld_in) dat_q[0] <= dat_in;
                for (int s = 1; s < STAGES; s++) begin
                    vld_q[s] <= vld_q[s-1];
                    col_q[s] <= col_q[s-1];
                    if (vld_q[s-1]) dat_q[s] <= dat_q[s-1];
                end
            end
        end

        assign vld_out = vld_q[STAGES-1];
        assign dat_out = dat_q[STAGES-1];
        assign col_out = col_q[STAGES-1];
    end

endmodule

// File: rtl/blram_dp.sv
// Purpose: dual-port block RAM, port A read/write, port B read-only, optional
//          zero-clear sequence after reset.
// Latency: RD_LAT cycles request-to-valid on both ports, fully pipelined.
// Backpressure: none; requests are dropped while busy or rst is high.
// Ports: clk/rst; busy; port A enA/wrEnA/addrA/dataA_in -> dataA_out/validA;
//        port B enB/addrB -> dataB_out/validB/collision.
module blram_dp
    import blram_pkg::*;
#(
    parameter int SIZE         = 8,
    parameter int DEPTH        = 2**SIZE,
    parameter int WIDTH        = 16,
    parameter int RD_LAT       = 1,
    parameter int WR_MODE      = 0,
    parameter int CLEAR_ON_RST = 0
) (
    input  logic             clk,
    input  logic             rst,
    output logic             busy,
    input  logic             enA,
    input  logic             wrEnA,
    input  logic [SIZE-1:0]  addrA,
    input  logic [WIDTH-1:0] dataA_in,
    output logic [WIDTH-1:0] dataA_out,
    output logic             validA,
    input  logic             enB,
    input  logic [SIZE-1:0]  addrB,
    output logic [WIDTH-1:0] dataB_out,
    output logic             validB,
    output logic             collision
);

    localparam logic [SIZE-1:0] LAST_ADDR = SIZE'(DEPTH - 1);
    localparam logic [SIZE:0]   DEPTH_W   = (SIZE+1)'(DEPTH);
    localparam int              STAGES    = lat_stages(RD_LAT);

    logic [WIDTH-1:0] mem [0:DEPTH-1];

    state_e          state_q, state_d;
    logic [SIZE-1:0] clr_addr_q, clr_addr_d;
    logic            clearing;

    // ---------------- controller: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RESET;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    // ---------------- controller: next state ----------------
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        case (state_q)
            ST_RESET: state_d = (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_RUN;
            ST_CLEAR: begin
                clr_addr_d = clr_addr_q + SIZE'(1);
                if (clr_addr_q == LAST_ADDR) state_d = ST_RUN;
            end
            ST_RUN:   state_d = ST_RUN;
            default:  state_d = ST_RESET;
        endcase
    end

    // ---------------- controller: outputs ----------------
    always_comb begin
        busy     = (state_q == ST_CLEAR) || ((state_q == ST_RESET) && (CLEAR_ON_RST != 0));
        clearing = (state_q == ST_CLEAR) && !rst;
    end

    // ---------------- request qualification ----------------
    logic a_go, b_go, a_in_rng, b_in_rng, a_wr, collide;

    always_comb begin
        a_go     = enA && !busy && !rst;
        b_go     = enB && !busy && !rst;
        a_in_rng = {1'b0, addrA} < DEPTH_W;
        b_in_rng = {1'b0, addrB} < DEPTH_W;
        // Out-of-range writes are dropped, so they can never collide with B.
        a_wr     = a_go && wrEnA && a_in_rng;
        collide  = a_wr && b_go && b_in_rng && (addrA == addrB);
    end

    // Single write port shared by the clear sequence and port A.
    logic             wr_en;
    logic [SIZE-1:0]  wr_addr;
    logic [WIDTH-1:0] wr_dat;

    always_comb begin
        wr_en   = a_wr;
        wr_addr = addrA;
        wr_dat  = dataA_in;
        if (clearing) begin
            wr_en   = 1'b1;
            wr_addr = clr_addr_q;
            wr_dat  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_dat;
    end

    // Read data as it will be registered at the request edge. Read-first
    // naturally sees the old word; write-first forwards the write data.
    logic [WIDTH-1:0] a_rd_d, b_rd_d;

    always_comb begin
        a_rd_d = '0;
        if (a_in_rng) begin
            if ((WR_MODE == WR_WRITE_FIRST) && wrEnA) a_rd_d = dataA_in;
            else                                      a_rd_d = mem[addrA];
        end
        b_rd_d = '0;
        if (b_in_rng) begin
            if ((WR_MODE == WR_WRITE_FIRST) && collide) b_rd_d = dataA_in;
            else                                        b_rd_d = mem[addrB];
        end
    end

    // RAM output registers: the first cycle of read latency.
    logic             a_vld_q, b_vld_q, b_col_q;
    logic [WIDTH-1:0] a_dat_q, b_dat_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_vld_q <= 1'b0;
            b_vld_q <= 1'b0;
            b_col_q <= 1'b0;
            a_dat_q <= '0;
            b_dat_q <= '0;
        end else begin
            a_vld_q <= a_go;
            b_vld_q <= b_go;
            b_col_q <= collide;
            if (a_go) a_dat_q <= a_rd_d;
            if (b_go) b_dat_q <= b_rd_d;
        end
    end

    logic unused_col_a;

    blram_lat_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) u_pipe_a (
        .clk     (clk),
        .rst     (rst),
        .vld_in  (a_vld_q),
        .dat_in  (a_dat_q),
        .col_in  (1'b0),
        .vld_out (validA),
        .dat_out (dataA_out),
        .col_out (unused_col_a)
    );

    blram_lat_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) u_pipe_b (
        .clk     (clk),
        .rst     (rst),
        .vld_in  (b_vld_q),
        .dat_in  (b_dat_q),
        .col_in  (b_col_q),
        .vld_out (validB),
        .dat_out (dataB_out),
        .col_out (collision)
    );

endmodule

// File: tb/tb_blram_dp.sv
// Three instances with different parameter sets share one clock:
//   u0: DEPTH=200, RD_LAT=2, read-first      u1: DEPTH=256, RD_LAT=3, write-first
//   u2: DEPTH=16,  RD_LAT=1, read-first, clear-on-reset
module tb_blram_dp;

    typedef struct {
        int          due;
        logic [15:0] dat;
        logic        col;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst     [3];
    logic        busy    [3];
    logic        en_a    [3];
    logic        we_a    [3];
    logic [7:0]  addr_a  [3];
    logic [15:0] din_a   [3];
    logic [15:0] dout_a  [3];
    logic        vld_a   [3];
    logic        en_b    [3];
    logic [7:0]  addr_b  [3];
    logic [15:0] dout_b  [3];
    logic        vld_b   [3];
    logic        col_b   [3];

    always #5 clk = ~clk;

    blram_dp #(.SIZE(8), .DEPTH(200), .WIDTH(16), .RD_LAT(2), .WR_MODE(0), .CLEAR_ON_RST(0)) u0 (
        .clk(clk), .rst(rst[0]), .busy(busy[0]),
        .enA(en_a[0]), .wrEnA(we_a[0]), .addrA(addr_a[0]), .dataA_in(din_a[0]),
        .dataA_out(dout_a[0]), .validA(vld_a[0]),
        .enB(en_b[0]), .addrB(addr_b[0]), .dataB_out(dout_b[0]), .validB(vld_b[0]),
        .collision(col_b[0]));

    blram_dp #(.SIZE(8), .DEPTH(256), .WIDTH(16), .RD_LAT(3), .WR_MODE(1), .CLEAR_ON_RST(0)) u1 (
        .clk(clk), .rst(rst[1]), .busy(busy[1]),
        .enA(en_a[1]), .wrEnA(we_a[1]), .addrA(addr_a[1]), .dataA_in(din_a[1]),
        .dataA_out(dout_a[1]), .validA(vld_a[1]),
        .enB(en_b[1]), .addrB(addr_b[1]), .dataB_out(dout_b[1]), .validB(vld_b[1]),
        .collision(col_b[1]));

    blram_dp #(.SIZE(8), .DEPTH(16), .WIDTH(16), .RD_LAT(1), .WR_MODE(0), .CLEAR_ON_RST(1)) u2 (
        .clk(clk), .rst(rst[2]), .busy(busy[2]),
        .enA(en_a[2]), .wrEnA(we_a[2]), .addrA(addr_a[2]), .dataA_in(din_a[2]),
        .dataA_out(dout_a[2]), .validA(vld_a[2]),
        .enB(en_b[2]), .addrB(addr_b[2]), .dataB_out(dout_b[2]), .validB(vld_b[2]),
        .collision(col_b[2]));

    function automatic int dep_of(input int i);
        return (i == 0) ? 200 : (i == 1) ? 256 : 16;
    endfunction
    function automatic int lat_of(input int i);
        return (i == 0) ? 2 : (i == 1) ? 3 : 1;
    endfunction
    function automatic bit wf_of(input int i);
        return (i == 1);
    endfunction

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          rst_smp [3];
    bit          quiet   [3];
    logic [15:0] ref_mem [3][256];
    logic [15:0] last_a  [3];
    logic [15:0] last_b  [3];
    exp_t        qa [3][$];
    exp_t        qb [3][$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 3; i++) rst_smp[i] <= rst[i];
    end

    task automatic chk(input string name, input int i, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s u%0d cycle %0d: got %0h expected %0h", name, i, cyc, act, exp);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst_smp[i]) begin
                chk("reset_outputs", i, {29'd0, vld_a[i], dout_a[i], vld_b[i], dout_b[i], col_b[i]}, 64'd0);
                last_a[i] = '0;
                last_b[i] = '0;
            end else begin
                bit   ev;
                exp_t e;
                ev = (qa[i].size() > 0) && (qa[i][0].due == cyc);
                chk("validA", i, 64'(vld_a[i]), 64'(ev));
                if (ev) begin
                    e = qa[i].pop_front();
                    chk("dataA", i, 64'(dout_a[i]), 64'(e.dat));
                    last_a[i] = e.dat;
                end else begin
                    chk("holdA", i, 64'(dout_a[i]), 64'(last_a[i]));
                end
                ev = (qb[i].size() > 0) && (qb[i][0].due == cyc);
                chk("validB", i, 64'(vld_b[i]), 64'(ev));
                if (ev) begin
                    e = qb[i].pop_front();
                    chk("dataB", i, 64'(dout_b[i]), 64'(e.dat));
                    chk("collision", i, 64'(col_b[i]), 64'(e.col));
                    last_b[i] = e.dat;
                end else begin
                    chk("holdB", i, 64'(dout_b[i]), 64'(last_b[i]));
                    chk("collision_idle", i, 64'(col_b[i]), 64'd0);
                end
            end
        end
    end

    // ---------------- stimulus + reference model ----------------
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            en_a[i] = 1'b0;
            we_a[i] = 1'b0;
            en_b[i] = 1'b0;
        end
    endtask

    // Drive one request pair for the next edge and record what it must return.
    task automatic issue(input int i, input bit ea, input bit wa, input int aa,
                         input logic [15:0] da, input bit eb, input int ab);
        exp_t e;
        bit   wr_ok;
        en_a[i]   = ea;
        we_a[i]   = wa;
        addr_a[i] = aa[7:0];
        din_a[i]  = da;
        en_b[i]   = eb;
        addr_b[i] = ab[7:0];
        if (rst[i] || quiet[i]) return;
        wr_ok = ea && wa && (aa < dep_of(i));
        if (eb) begin
            e.due = cyc + lat_of(i);
            e.col = 1'b0;
            if (ab >= dep_of(i))           e.dat = '0;
            else if (wr_ok && aa == ab) begin
                e.col = 1'b1;
                e.dat = wf_of(i) ? da : ref_mem[i][ab];
            end else                       e.dat = ref_mem[i][ab];
            qb[i].push_back(e);
        end
        if (ea) begin
            e.due = cyc + lat_of(i);
            e.col = 1'b0;
            if (aa >= dep_of(i))      e.dat = '0;
            else if (wa && wf_of(i))  e.dat = da;
            else                      e.dat = ref_mem[i][aa];
            qa[i].push_back(e);
            if (wr_ok) ref_mem[i][aa] = da;
        end
    endtask

    initial begin
        int cnt;
        int bad;
        logic [15:0] v;
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1; en_a[i] = 1'b0; we_a[i] = 1'b0; en_b[i] = 1'b0;
            addr_a[i] = '0; addr_b[i] = '0; din_a[i] = '0;
            quiet[i] = 1'b0; last_a[i] = '0; last_b[i] = '0;
        end
        // Preload while everything is held in reset.
        for (int k = 0; k < 256; k++) begin
            v = 16'($urandom);
            if (k < 200) begin u0.mem[k] = v; ref_mem[0][k] = v; end
            v = 16'($urandom);
            u1.mem[k] = v; ref_mem[1][k] = v;
            if (k < 16) begin u2.mem[k] = 16'hFFFF; ref_mem[2][k] = 16'h0000; end
        end
        begin
            logic [15:0] pre [5];
            pre = '{16'd5, 16'd8, 16'd15, 16'd17, 16'd22};
            for (int k = 0; k < 5; k++) begin u0.mem[10+k] = pre[k]; ref_mem[0][10+k] = pre[k]; end
        end
        for (int i = 0; i < 2; i++) begin
            ref_mem[i][3] = 16'd7; ref_mem[i][20] = 16'h3C3C;
        end
        u0.mem[3] = 16'd7; u0.mem[20] = 16'h3C3C;
        u1.mem[3] = 16'd7; u1.mem[20] = 16'h3C3C;
        step(); step(); step();

        // Release reset; u2 runs its clear sequence and must ignore requests.
        quiet[2] = 1'b1;
        for (int i = 0; i < 3; i++) rst[i] = 1'b0;
        step();
        cnt = 0;
        while (busy[2] === 1'b1 && cnt < 40) begin
            cnt++;
            if (cnt == 3) issue(2, 1, 1, 5, 16'h5555, 1, 5);
            step();
        end
        chk("busy_cycles", 2, 64'(cnt), 64'd16);
        quiet[2] = 1'b0;
        bad = 0;
        for (int k = 0; k < 16; k++) if (u2.mem[k] !== 16'h0000) bad++;
        chk("clear_mem_words", 2, 64'(bad), 64'd0);
        for (int k = 0; k < 16; k++) begin
            issue(2, 1, 0, k, 16'h0, 1, 15 - k);
            step();
        end

        // Back-to-back B reads of the preloaded words.
        for (int k = 10; k < 15; k++) begin
            issue(0, 0, 0, 0, 16'h0, 1, k);
            step();
        end

        // Read-first vs write-first on address 3, then a read-back.
        issue(0, 1, 1, 3, 16'd9, 0, 0);
        issue(1, 1, 1, 3, 16'd9, 0, 0);
        step();
        issue(0, 1, 0, 3, 16'd0, 0, 0);
        issue(1, 1, 0, 3, 16'd0, 0, 0);
        step();

        // Same-cycle write A / read B on address 20.
        issue(0, 1, 1, 20, 16'h00AA, 1, 20);
        issue(1, 1, 1, 20, 16'h00AA, 1, 20);
        step();

        // Out-of-range write on the 200-word instance must not alias.
        issue(0, 1, 1, 250, 16'h1234, 0, 0);
        step();
        issue(0, 1, 0, 250, 16'h0, 1, 250);
        step();
        chk("oor_alias_word", 0, 64'(u0.mem[50]), 64'(ref_mem[0][50]));

        // Random traffic on all instances, with frequent same-address pairs.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 3; i++) begin
                int aa, ab;
                aa = (i == 2) ? $urandom_range(0, 31) : $urandom_range(0, 255);
                ab = ($urandom_range(0, 3) == 0) ? aa
                   : ((i == 2) ? $urandom_range(0, 31) : $urandom_range(0, 255));
                issue(i, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), aa,
                      16'($urandom), bit'($urandom_range(0, 1)), ab);
            end
            step();
        end
        for (int k = 0; k < 5; k++) step();

        // Reset while reads are in flight on the RD_LAT=3 instance.
        issue(1, 1, 0, 7, 16'h0, 1, 9);
        step();
        issue(1, 1, 0, 8, 16'h0, 0, 0);
        step();
        rst[1] = 1'b1;
        step();
        qa[1].delete();
        qb[1].delete();
        rst[1] = 1'b0;
        for (int k = 0; k < 6; k++) step();
        bad = 0;
        for (int k = 0; k < 256; k++) if (u1.mem[k] !== ref_mem[1][k]) bad++;
        chk("mem_after_reset", 1, 64'(bad), 64'd0);

        for (int k = 0; k < 6; k++) step();
        for (int i = 0; i < 3; i++) begin
            chk("pending_A", i, 64'(qa[i].size()), 64'd0);
            chk("pending_B", i, 64'(qb[i].size()), 64'd0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/blram_dp.md
BLRAM_DP -- requirements
Module: blram_dp

Interface
REQ-001 The module SHALL have a parameter SIZE, default 8, giving the address width in bits.
REQ-002 The module SHALL have a parameter DEPTH, default 2**SIZE, giving the number of words, with DEPTH <= 2**SIZE.
REQ-003 The module SHALL have a parameter WIDTH, default 16, giving the data word width in bits.
REQ-004 The module SHALL have a parameter RD_LAT, default 1, legal 1..3, giving the number of cycles from request to data.
REQ-005 The module SHALL have a parameter WR_MODE, default 0: 0 = read-first, 1 = write-first.
REQ-006 The module SHALL have a parameter CLEAR_ON_RST, default 0: 1 = zero all words after reset.
REQ-007 The module SHALL use one clock and a synchronous, active-high reset.
REQ-008 The module SHALL have the following ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  synchronous reset, active-high
- busy  out  1  clear sequence in progress; requests ignored
- enA  in  1  port A request
- wrEnA  in  1  port A write qualifier (with enA)
- addrA  in  SIZE  port A address
- dataA_in  in  WIDTH  port A write data
- dataA_out  out  WIDTH  port A read data
- validA  out  1  dataA_out valid
- enB  in  1  port B read request
- addrB  in  SIZE  port B address
- dataB_out  out  WIDTH  port B read data
- validB  out  1  dataB_out valid
- collision  out  1  port B read hit the word port A wrote in the same cycle; aligned with validB

Function
REQ-009 The state machine SHALL have three states: ST_RESET (rst high), ST_CLEAR, and ST_RUN.
- From ST_RESET, when rst falls: go to ST_CLEAR if CLEAR_ON_RST=1, else to ST_RUN.
REQ-010 ST_CLEAR SHALL write zero to one address per cycle, from 0 up to DEPTH-1, then enter ST_RUN on the next edge (DEPTH cycles total).
REQ-011 busy SHALL be 1 in ST_CLEAR, and also in ST_RESET when CLEAR_ON_RST=1; otherwise busy SHALL be 0.
REQ-012 While busy=1 or rst=1, enA and enB SHALL be ignored: no write, and no valid is produced.
REQ-013 Requests SHALL be fully pipelined: one request per port per cycle, with no back-pressure.
REQ-014 A request sampled at edge N SHALL make validX=1, with dataX_out stable, for exactly the cycle after edge N+RD_LAT-1.
REQ-015 An enA=1, wrEnA=1 request SHALL update mem[addrA] at edge N and SHALL also return data on port A.
- WR_MODE=0 returns the old word.
- WR_MODE=1 returns dataA_in.
REQ-016 When port A writes and port B reads the same address in the same cycle:
- dataB_out SHALL follow the WR_MODE rule.
- collision SHALL be 1 alongside that validB.
REQ-017 If addrA >= DEPTH, writes SHALL be dropped and reads SHALL return 0 with valid still asserted; the same applies to addrB.
REQ-018 When validX=0, dataX_out SHALL hold its last value; collision SHALL be 0 whenever validB=0.
REQ-019 Memory contents SHALL be readable and writable hierarchically as array mem[0:DEPTH-1], so benches can preload it.

Reset
REQ-020 While rst=1, the module SHALL drive dataA_out=0, dataB_out=0, validA=0, validB=0, and collision=0, one cycle after the edge where rst is sampled.
REQ-021 Reset SHALL flush all in-flight read pipeline stages; no valid SHALL emerge after reset from a request made before it.
REQ-022 With CLEAR_ON_RST=0, reset SHALL NOT alter memory contents.
REQ-023 Reset asserted during ST_CLEAR SHALL restart clearing from address 0 after rst falls.

Structure
REQ-024 Package blram_pkg SHALL hold the state encoding (ST_RESET, ST_CLEAR, ST_RUN) and the WR_MODE constants (WR_READ_FIRST=0, WR_WRITE_FIRST=1).
REQ-025 A sub-module blram_lat_pipe SHALL implement the RD_LAT-deep delay line for {valid, data, collision}, with synchronous flush, instantiated once per port.
REQ-026 The memory array SHALL be a single inferred block RAM, with both ports' reads registered and no asynchronous read path.

Verification
REQ-027 Preload and pipeline: preload mem[10..14]={5,8,15,17,22} with RD_LAT=2, then issue back-to-back B reads of addresses 10..14.
- validB SHALL be high for 5 consecutive cycles, starting 2 cycles after the first request.
- dataB_out SHALL be 5, 8, 15, 17, 22.
REQ-028 Read-first versus write-first: with mem[3]=7, A writes 9 to address 3.
- WR_MODE=0: dataA_out=7.
- WR_MODE=1: dataA_out=9.
- A subsequent A read of address 3 SHALL return 9.
REQ-029 Collision: A writes 0x00AA to address 20 while B reads address 20 in the same cycle.
- collision=1 with validB.
- dataB_out = old word (WR_MODE=0) or 0x00AA (WR_MODE=1).
REQ-030 Clear sequence: CLEAR_ON_RST=1, DEPTH=16, mem preloaded with 0xFFFF.
- After rst falls, busy=1 for exactly 16 cycles.
- A request issued during busy yields no valid.
- Every word reads 0 afterwards.
REQ-031 Reset mid-flight: with RD_LAT=3, issue 3 reads, then assert rst for 1 cycle.
- No validA/validB SHALL appear from those reads.
- Memory is unchanged (CLEAR_ON_RST=0).
REQ-032 Out of range: with DEPTH=200, write 0x1234 to address 250.
- A read of address 250 SHALL return 0 with validA=1.
- mem[250 mod 200] SHALL be unchanged.
